int_dot_product_engine: RTL and testbench
=========================================

INT_DOT_PRODUCT_ENGINE -- requirements
Module: int_dot_product_engine

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: address and vec_length width.
REQ-002 SHALL have parameter DATA_W, default 32: operand and result width.
REQ-003 SHALL use one clock and an asynchronous, active-low reset. Ports are clk and rst_n.
REQ-004 SHALL have port `clk  input  1`: rising-edge clock.
REQ-005 SHALL have port `rst_n  input  1`: asynchronous active-low reset.
REQ-006 SHALL have port `start  input  1`: request pulse, sampled only in IDLE.
REQ-007 SHALL have port `vec_length  input  ADDR_W`: element count, latched on an accepted start.
REQ-008 SHALL have port `patch_data  input  DATA_W`: signed operand A, valid one cycle after patch_addr.
REQ-009 SHALL have port `filter_data  input  DATA_W`: signed operand B, valid one cycle after filter_addr.
REQ-010 SHALL have port `patch_addr  output  ADDR_W`: read address for operand A.
REQ-011 SHALL have port `filter_addr  output  ADDR_W`: read address for operand B, always equal to patch_addr.
REQ-012 SHALL have port `done  output  1`: one-cycle completion pulse.
REQ-013 SHALL have port `result  output  DATA_W`: saturated signed dot product.
REQ-014 SHALL have port `overflow  output  1`: set when the last result saturated.
REQ-015 SHALL have port `busy  output  1`: high whenever state is not IDLE.

Function
REQ-016 SHALL implement states IDLE, FETCH, DRAIN and FINISH.
REQ-017 In IDLE with start=1 at clock edge E0, SHALL latch L=vec_length, clear the accumulator and set addr=0.
- If L>0, next state is FETCH.
- If L=0, next state is FINISH.
REQ-018 SHALL issue addresses 0..L-1 on consecutive cycles 1..L, counting cycles from the start cycle as 0. At the edge ending cycle L, next state is DRAIN.
REQ-019 SHALL assume a read latency of exactly 1 cycle: data for the address in cycle i is sampled in cycle i+1.
REQ-020 SHALL register the full-precision signed product (2*DATA_W bits) one edge after the data is sampled.
REQ-021 SHALL add the product into a signed accumulator of 2*DATA_W+ADDR_W bits on the following edge. This accumulator width SHALL never overflow.
REQ-022 SHALL stay in DRAIN until the last product has been accumulated, then enter FINISH.
REQ-023 In FINISH, SHALL drive done=1 for exactly one cycle, then return to IDLE.
- For L>0, done is high in cycle L+3.
- For L=0, done is high in cycle 1 with result=0.
REQ-024 SHALL update result and overflow on the edge that raises done, and hold them until the next done.
REQ-025 SHALL saturate the accumulator to the DATA_W signed range when producing result:
- accumulator > 0x7FFFFFFF -> result 0x7FFFFFFF, overflow=1;
- accumulator < -0x80000000 -> result 0x80000000, overflow=1;
- otherwise result = accumulator with overflow=0.
REQ-026 SHALL ignore start whenever state is not IDLE, with no effect on the operation in progress.
REQ-027 SHALL accept a start asserted in the cycle after done, since state is IDLE by then. Back-to-back operations need no gap beyond that cycle.
REQ-028 SHALL hold patch_addr and filter_addr at 0 in IDLE, FINISH and DRAIN.
REQ-029 SHALL keep busy low in IDLE and high in FETCH, DRAIN and FINISH.

Reset
REQ-030 On rst_n=0, SHALL asynchronously force:
- state IDLE;
- done=0, busy=0, result=0, overflow=0;
- patch_addr=0, filter_addr=0;
- accumulator and product register = 0.
REQ-031 SHALL abort any operation in progress when rst_n is asserted: no done, no result update. It SHALL accept a new start on the first edge after rst_n deasserts.

Verification
REQ-032 L=2, A=[3,4], B=[5,6], start in cycle 0 -> addresses 0,1 in cycles 1,2; done=1 in cycle 5 only; result=39; overflow=0.
REQ-033 L=2, A=[-7,2], B=[3,-5] -> result=0xFFFFFFE1 (-31), overflow=0; L=0 -> done in cycle 1, result=0, addresses stay 0.
REQ-034 L=4, all A=B=0x7FFFFFFF -> result=0x7FFFFFFF, overflow=1; L=4, A=0x80000000, B=0x7FFFFFFF -> result=0x80000000, overflow=1.
REQ-035 start re-pulsed in cycles 2 and 3 of an L=3 operation -> ignored; exactly one done, in cycle 6, with the correct result.
REQ-036 rst_n low during cycle 3 of an L=4 operation -> all outputs 0 immediately, no done; a later start with L=1, A=[9], B=[9] -> result=81.
REQ-037 Two back-to-back operations, second start in the cycle after the first done -> both done pulses present and both results correct.

Source files
------------

// File: rtl/int_dot_product_engine_if.sv
// Bus bundle for the integer dot-product engine: control, operand reads and result.
interface int_dot_product_engine_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) ();
  logic              start;
  logic [ADDR_W-1:0] vec_length;
  logic [DATA_W-1:0] patch_data;
  logic [DATA_W-1:0] filter_data;
  logic [ADDR_W-1:0] patch_addr;
  logic [ADDR_W-1:0] filter_addr;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              overflow;
  logic              busy;

  // Requester side: issues start, serves operand reads, consumes result.
  modport master (
    output start, vec_length, patch_data, filter_data,
    input  patch_addr, filter_addr, done, result, overflow, busy
  );

  // Engine side.
  modport slave (
    input  start, vec_length, patch_data, filter_data,
    output patch_addr, filter_addr, done, result, overflow, busy
  );
endinterface

// File: rtl/int_dot_product_engine.sv
// Integer dot-product engine: streams L operand pairs from two 1-cycle-latency
// memories, multiplies at full precision, accumulates without overflow and
// returns the sum saturated to DATA_W bits with an overflow flag.
module int_dot_product_engine #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  int_dot_product_engine_if.slave  bus
);

  localparam int PW = 2 * DATA_W;
  localparam int AW = PW + ADDR_W;

  // Saturation bounds, sign-extended to accumulator width.
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDR_W-1:0]        len_q, len_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic                     rd_vld_q, rd_vld_d;     // operand data valid this cycle
  logic                     prod_vld_q, prod_vld_d; // prod_q holds an unaccumulated product
  logic signed [PW-1:0]     prod_q, prod_d;
  logic signed [AW-1:0]     acc_q, acc_d;
  logic [DATA_W-1:0]        result_q, result_d;
  logic                     ovf_q, ovf_d;
  logic                     done_q, done_d;
  logic                     busy_q, busy_d;

  // Clamp the wide accumulator to the signed DATA_W range; MSB of return is overflow.
  function automatic logic [DATA_W:0] saturate(input logic signed [AW-1:0] acc);
    logic [DATA_W:0] r;
    if (acc > SAT_MAX) begin
      r = {1'b1, SAT_MAX[DATA_W-1:0]};
    end else if (acc < SAT_MIN) begin
      r = {1'b1, SAT_MIN[DATA_W-1:0]};
    end else begin
      r = {1'b0, acc[DATA_W-1:0]};
    end
    return r;
  endfunction

  // Next-state, address sequencing, multiply/accumulate pipeline and result capture.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    addr_d     = addr_q;
    rd_vld_d   = (state_q == FETCH);
    prod_vld_d = rd_vld_q;
    prod_d     = prod_q;
    acc_d      = acc_q;
    result_d   = result_q;
    ovf_d      = ovf_q;

    if (rd_vld_q) begin
      prod_d = $signed(bus.patch_data) * $signed(bus.filter_data);
    end else begin
      prod_d = prod_q;
    end

    if (prod_vld_q) begin
      acc_d = acc_q + {{ADDR_W{prod_q[PW-1]}}, prod_q};
    end else begin
      acc_d = acc_q;
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          len_d  = bus.vec_length;
          acc_d  = {AW{1'b0}};
          addr_d = {ADDR_W{1'b0}};
          if (bus.vec_length == {ADDR_W{1'b0}}) begin
            state_d = FINISH;
          end else begin
            state_d = FETCH;
          end
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        if (addr_q == (len_q - {{(ADDR_W-1){1'b0}}, 1'b1})) begin
          addr_d  = {ADDR_W{1'b0}};
          state_d = DRAIN;
        end else begin
          addr_d  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          state_d = FETCH;
        end
      end
      DRAIN: begin
        // Once no read data is pending, the last product is being added this cycle.
        if (!rd_vld_q) begin
          state_d = FINISH;
        end else begin
          state_d = DRAIN;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == FINISH);
    if (state_d == FINISH) begin
      {ovf_d, result_d} = saturate(acc_d);
    end else begin
      result_d = result_q;
      ovf_d    = ovf_q;
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= {ADDR_W{1'b0}};
      addr_q     <= {ADDR_W{1'b0}};
      rd_vld_q   <= 1'b0;
      prod_vld_q <= 1'b0;
      prod_q     <= {PW{1'b0}};
      acc_q      <= {AW{1'b0}};
      result_q   <= {DATA_W{1'b0}};
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      rd_vld_q   <= rd_vld_d;
      prod_vld_q <= prod_vld_d;
      prod_q     <= prod_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.patch_addr  = addr_q;
  assign bus.filter_addr = addr_q;
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.overflow    = ovf_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_int_dot_product_engine.sv
// Self-checking bench for int_dot_product_engine: directed cases plus random
// vectors against an arithmetic reference model, checked cycle by cycle.
module tb_int_dot_product_engine;
  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int_dot_product_engine_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  int_dot_product_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int mem_a [1024];
  int mem_b [1024];
  logic [DW-1:0] last_res;
  logic          last_ovf;

  // Operand memories with one cycle of read latency.
  always @(posedge clk) begin
    bus.patch_data  <= mem_a[bus.patch_addr];
    bus.filter_data <= mem_b[bus.filter_addr];
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact signed sum of products, then clamp to 32-bit signed.
  task automatic model(input int len, output logic [DW-1:0] r, output logic o);
    logic signed [127:0] s;
    longint p;
    s = 128'sd0;
    for (int i = 0; i < len; i++) begin
      p = longint'(mem_a[i]) * longint'(mem_b[i]);
      s = s + p;
    end
    if (s > 128'sd2147483647) begin
      r = 32'h7FFF_FFFF; o = 1'b1;
    end else if (s < -128'sd2147483648) begin
      r = 32'h8000_0000; o = 1'b1;
    end else begin
      r = s[31:0]; o = 1'b0;
    end
  endtask

  // Runs one operation starting at the current negedge (cycle 0); returns in the done cycle.
  task automatic run_op(input int len, input bit repulse);
    logic [DW-1:0] er;
    logic          eo;
    int            fin;
    logic [AW-1:0] ea;
    model(len, er, eo);
    fin = (len == 0) ? 1 : len + 3;
    check_eq("idle_busy", bus.busy, 0);
    check_eq("idle_done", bus.done, 0);
    check_eq("idle_addr", bus.patch_addr, 0);
    check_eq("hold_result", bus.result, last_res);
    check_eq("hold_ovf", bus.overflow, last_ovf);
    bus.vec_length = len[AW-1:0];
    bus.start = 1'b1;
    for (int c = 1; c <= fin; c++) begin
      @(negedge clk);
      if (repulse && (c == 2 || c == 3)) begin
        bus.start = 1'b1;
        bus.vec_length = 10'd7;
      end else begin
        bus.start = 1'b0;
      end
      ea = (len > 0 && c <= len) ? AW'(c - 1) : {AW{1'b0}};
      check_eq("busy", bus.busy, 1);
      check_eq("done", bus.done, (c == fin) ? 1 : 0);
      check_eq("patch_addr", bus.patch_addr, ea);
      check_eq("filter_addr", bus.filter_addr, ea);
      if (c == fin) begin
        check_eq("result", bus.result, er);
        check_eq("overflow", bus.overflow, eo);
      end else begin
        check_eq("result_hold", bus.result, last_res);
      end
    end
    last_res = er;
    last_ovf = eo;
  endtask

  initial begin
    int len;
    bus.start = 1'b0;
    bus.vec_length = '0;
    last_res = '0;
    last_ovf = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = 0;
      mem_b[i] = 0;
    end
    repeat (2) @(negedge clk);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_result", bus.result, 0);
    check_eq("rst_ovf", bus.overflow, 0);
    check_eq("rst_addr", bus.patch_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic example: 3*5 + 4*6 = 39.
    mem_a[0] = 3; mem_a[1] = 4; mem_b[0] = 5; mem_b[1] = 6;
    run_op(2, 1'b0);
    @(negedge clk);
    check_eq("ex1_result", bus.result, 64'd39);

    // Mixed signs: -21 + -10 = -31.
    mem_a[0] = -7; mem_a[1] = 2; mem_b[0] = 3; mem_b[1] = -5;
    run_op(2, 1'b0);
    @(negedge clk);
    check_eq("ex2_result", bus.result, 64'hFFFF_FFE1);

    // Zero length.
    run_op(0, 1'b0);
    @(negedge clk);
    check_eq("len0_result", bus.result, 64'd0);

    // Positive and negative saturation.
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = 32'h7FFF_FFFF; mem_b[i] = 32'h7FFF_FFFF;
    end
    run_op(4, 1'b0);
    @(negedge clk);
    check_eq("sat_pos_result", bus.result, 64'h7FFF_FFFF);
    check_eq("sat_pos_ovf", bus.overflow, 1);
    for (int i = 0; i < 4; i++) mem_a[i] = 32'h8000_0000;
    run_op(4, 1'b0);
    @(negedge clk);
    check_eq("sat_neg_result", bus.result, 64'h8000_0000);
    check_eq("sat_neg_ovf", bus.overflow, 1);

    // Start re-pulsed mid-operation is ignored.
    mem_a[0] = 1; mem_a[1] = -2; mem_a[2] = 3;
    mem_b[0] = 10; mem_b[1] = 20; mem_b[2] = 30;
    run_op(3, 1'b1);
    @(negedge clk);
    check_eq("repulse_no_done", bus.done, 0);

    // Reset in cycle 3 of an L=4 operation.
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = i + 1; mem_b[i] = 2;
    end
    bus.vec_length = 10'd4;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", bus.busy, 0);
    check_eq("abort_done", bus.done, 0);
    check_eq("abort_result", bus.result, 0);
    check_eq("abort_ovf", bus.overflow, 0);
    check_eq("abort_addr", bus.patch_addr, 0);
    check_eq("abort_faddr", bus.filter_addr, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("abort_no_done", bus.done, 0);
    end
    rst_n = 1'b1;
    last_res = '0;
    last_ovf = 1'b0;
    mem_a[0] = 9; mem_b[0] = 9;
    run_op(1, 1'b0);
    @(negedge clk);
    check_eq("post_rst_result", bus.result, 64'd81);

    // Random back-to-back operations.
    for (int k = 0; k < 24; k++) begin
      len = $urandom_range(0, 8);
      for (int i = 0; i < 8; i++) begin
        if (k % 2 == 0) begin
          mem_a[i] = int'($urandom_range(0, 200)) - 100;
          mem_b[i] = int'($urandom_range(0, 200)) - 100;
        end else begin
          mem_a[i] = int'($urandom());
          mem_b[i] = int'($urandom());
        end
      end
      run_op(len, 1'b0);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
